// File: rtl/picomips_ctrl_pkg.sv
// rtl/picomips_ctrl_pkg.sv - shared state encoding and widths for the picoMIPS run controller
package picomips_ctrl_pkg;

    localparam int CTRL_STATE_W = 3;
    localparam int INSTR_CNT_W  = 16;

    typedef enum logic [CTRL_STATE_W-1:0] {
        CTRL_RESET = 3'd0,
        CTRL_HALT  = 3'd1,
        CTRL_STEP  = 3'd2,
        CTRL_RUN   = 3'd3,
        CTRL_BREAK = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/picomips_debounce.sv
// rtl/picomips_debounce.sv - 2-FF synchronizer, stability debouncer and rising-edge pulse
module picomips_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        // cnt holds how many earlier consecutive cycles already disagreed
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = db_d & ~db_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = db_q;
    assign rise  = rise_q;

endmodule

// File: rtl/picomips_run_ctrl.sv
// rtl/picomips_run_ctrl.sv - picoMIPS reset/enable/step controller; PICOMIPS_BRKPT_EN adds a PC breakpoint
module picomips_run_ctrl
    import picomips_ctrl_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int DEB_CYCLES = 50000,
    parameter int PRESCALE   = 1000000,
    parameter int RST_HOLD   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef PICOMIPS_BRKPT_EN
    input  logic                    bp_valid,
    input  logic [PC_W-1:0]         bp_addr,
`endif
    input  logic                    sw_run,
    input  logic                    sw_step,
    input  logic                    halt_req,
    input  logic [PC_W-1:0]         pc,
    output logic                    cpu_rst_n,
    output logic                    cpu_en,
    output logic [CTRL_STATE_W-1:0] state,
    output logic [INSTR_CNT_W-1:0]  instr_cnt
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
    localparam logic [INSTR_CNT_W-1:0] CNT_MAX = '1;

    ctrl_state_t            state_q, state_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;
    logic                   en_c;
    logic                   tick;
    logic                   bp_hit;
    logic                   run_db;
    logic                   step_pulse;
    logic                   unused_run_rise;
    logic                   unused_step_level;

    picomips_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sw_run),
        .level (run_db),
        .rise  (unused_run_rise)
    );

    picomips_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sw_step),
        .level (unused_step_level),
        .rise  (step_pulse)
    );

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

`ifdef PICOMIPS_BRKPT_EN
    // Checked only on a tick so the instruction at bp_addr is held back, not skipped
    assign bp_hit = bp_valid && (pc == bp_addr) && tick;
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign bp_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        en_c    = 1'b0;
        case (state_q)
            CTRL_RESET: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = CTRL_HALT;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            CTRL_HALT: begin
                if (run_db) begin
                    state_d = CTRL_RUN;
                end else if (step_pulse) begin
                    state_d = CTRL_STEP;
                end
            end
            CTRL_STEP: begin
                en_c    = 1'b1;
                state_d = CTRL_HALT;
            end
            CTRL_RUN: begin
                if (!run_db) begin
                    state_d = CTRL_HALT;
                end else if (halt_req || bp_hit) begin
                    state_d = CTRL_BREAK;
                end else begin
                    en_c = tick;
                end
            end
            CTRL_BREAK: begin
                if (!run_db) begin
                    state_d = CTRL_HALT;
                end else if (step_pulse) begin
                    state_d = CTRL_STEP;
                end
            end
            default: state_d = CTRL_RESET;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (en_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + INSTR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CTRL_RESET;
            pre_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cpu_rst_n = (state_q != CTRL_RESET);
    assign cpu_en    = en_c;
    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule
